seq_arithmetic: RTL

Parametrised, multi-cycle successor to the four-function calculator datapath. It performs unsigned add, subtract, multiply and divide on WIDTH-bit operands under a start/done handshake. Multiply uses iterative shift-add and divide uses restoring division, so the block scales in width without a combinational array multiplier or divider. It sits between operand/operation entry and the display/overflow-indicator logic and replaces the combinational mux-selected result path.

---
 rtl/arith_pkg.sv | 16 +
 rtl/arith_iter_step.sv | 36 +++
 rtl/seq_arithmetic.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared encodings for the sequential arithmetic unit
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/arith_iter_step.sv
// rtl/arith_iter_step.sv - one shift-add multiply or restoring divide iteration
module arith_iter_step
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] next_acc,
    output logic               qbit
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    // acc is {upper half, lower half}: product/multiplier for mul,
    // partial remainder/remaining dividend bits for div
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
        next_acc = '0;
        qbit     = 1'b0;
        if (mode == MODE_MUL) begin
            next_acc = {add_sum, acc[WIDTH-1:1]};
        end else begin
            qbit = ~trial[WIDTH];
            if (qbit) begin
                next_acc = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                next_acc = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/seq_arithmetic.sv
// rtl/seq_arithmetic.sv - multi-cycle unsigned add/sub/mul/div with start/done handshake
module seq_arithmetic
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [1:0]         operation,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] returnValue,
    output logic               overflow,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] ret_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] step_next;
    logic               step_qbit;
    logic               step_mode;

    assign sum       = {1'b0, x} + {1'b0, y};
    assign diff      = x + ~y + WIDTH'(1);
    assign step_mode = (op_q == OP_DIV) ? MODE_DIV : MODE_MUL;

    arith_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .mode     (step_mode),
        .next_acc (step_next),
        .qbit     (step_qbit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_ADD;
            x_q   <= '0;
            opnd  <= '0;
            acc   <= '0;
            ret_q <= '0;
            ovf_q <= 1'b0;
            rem_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= operation;
                        x_q  <= x;
                        opnd <= (operation == OP_MUL) ? x : y;
                        cnt  <= '0;
                        case (operation)
                            OP_ADD: begin
                                ret_q <= {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                                ovf_q <= sum[WIDTH];
                                rem_q <= '0;
                                state <= ST_DONE;
                            end
                            OP_SUB: begin
                                ret_q <= {{WIDTH{1'b0}}, diff};
                                ovf_q <= (x < y);
                                rem_q <= '0;
                                state <= ST_DONE;
                            end
                            OP_MUL: begin
                                acc   <= {{WIDTH{1'b0}}, y};
                                state <= ST_RUN;
                            end
                            default: begin
                                acc   <= {{WIDTH{1'b0}}, x};
                                state <= ST_RUN;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    acc <= step_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        if (op_q == OP_MUL) begin
                            ret_q <= step_next;
                            ovf_q <= |step_next[2*WIDTH-1:WIDTH];
                            rem_q <= '0;
                        end else if (opnd == '0) begin
                            // divide by zero still iterates; result is forced here
                            ret_q <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            ovf_q <= 1'b1;
                            rem_q <= x_q;
                        end else begin
                            ret_q <= {{WIDTH{1'b0}}, step_next[WIDTH-1:1], step_qbit};
                            ovf_q <= 1'b0;
                            rem_q <= step_next[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign returnValue = ret_q;
    assign overflow    = ovf_q;
    assign remainder   = rem_q;

endmodule
